uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver. It drains each received byte from the receiver's `dout`/`rdy` interface, acknowledges the byte with a one-cycle `rdy_clr` pulse, and stores it in a synchronous FIFO. The FIFO feeds a consumer over a first-word-fall-through valid/ready interface, so software or core logic can read bursts without losing bytes between reads.

## Interface
- `DEPTH`, default 16: FIFO entries; must be a power of two, at least 2.
- `ADDR_W`, default $clog2(DEPTH): pointer width; derived, never overridden.

- `clk50`  in  1  system clock; the same clock that drives the UART.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `rx_dout`  in  8  received byte from the UART receiver.
- `rx_rdy`  in  1  receiver holds a byte; stays high until cleared.
- `rx_rdy_clr`  out  1  one-cycle pulse that clears `rx_rdy`.
- `m_data`  out  8  head-of-FIFO byte; valid only while `m_valid` is high.
- `m_valid`  out  1  FIFO not empty.
- `m_ready`  in  1  consumer accepts `m_data`. A pop occurs when `m_valid && m_ready`.
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `overrun`  out  1  sticky drop flag. Present only with `UART_RX_FIFO_OVERRUN_EN`.
- `overrun_clr`  in  1  clears `overrun`. Present only with `UART_RX_FIFO_OVERRUN_EN`.

## Operation
- The capture FSM has two states, IDLE and WAIT_CLR.
  - **IDLE:** if `rx_rdy && !full`, the block pushes `rx_dout`, asserts `rx_rdy_clr` for one cycle, and goes to WAIT_CLR.
  - **WAIT_CLR:** no capture. The FSM returns to IDLE on the first cycle `rx_rdy` is sampled low. This prevents a stale `rx_rdy` from causing a double capture.
- The full test uses the registered `count` from the start of the cycle.
  - A pop in the same cycle does not enable a push when the FIFO is full.
  - The push happens one cycle later.
- FIFO behaviour:
  - Storage is circular, with `wr_ptr` and `rd_ptr` of ADDR_W bits that wrap from DEPTH-1 to 0.
  - `count` tracks occupancy and is +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
  - A pop while empty is ignored: `m_ready` has no effect when `m_valid` is low.
  - `m_data` is the combinational read of `mem[rd_ptr]`.
- Reset values:
  - State is IDLE.
  - `rx_rdy_clr` = 0.
  - `count` = 0, so `m_valid` = 0 and `full` = 0.
  - Both pointers = 0.
  - `overrun` = 0.
  - `m_data` is don't-care; memory contents are not reset.
- If reset is asserted mid-operation, all buffered bytes are lost. If `rx_rdy` is still high after reset, the FSM captures it normally in IDLE.

## Timing
- Byte accepted:
  - Cycle N: `rx_rdy` is sampled high in IDLE with `!full`.
  - Cycle N+1: `rx_rdy_clr` is high for exactly this cycle, the write is committed, `count` has incremented, and `m_valid` is high.
- Back-to-back receptions: the minimum spacing between captures is 3 cycles (IDLE → WAIT_CLR → IDLE). This is far below one UART character time.
- Pop: on a cycle with `m_valid && m_ready`, `rd_ptr` advances on the edge, and the next byte appears on `m_data` the same cycle that `rd_ptr` updates.
- `full`, `m_valid` and `count` are all derived from the registered count and carry no combinational path from `m_ready`.

## Configuration
- `UART_RX_FIFO_OVERRUN_EN` defined:
  - In IDLE with `rx_rdy && full`, the block asserts `rx_rdy_clr` for one cycle, discards `rx_dout`, sets `overrun`, and goes to WAIT_CLR.
  - `overrun` stays set until `overrun_clr` is sampled high. If a set and a clear occur in the same cycle, the set wins.
- `UART_RX_FIFO_OVERRUN_EN` undefined:
  - The `overrun` and `overrun_clr` ports are absent.
  - When full, the block leaves `rx_rdy` untouched and waits. The byte is captured once space frees.
  - Any overwrite inside the receiver is the receiver's own behaviour.

## Structure
- Shared package `uart_pkg` holds:
  - `UART_DATA_W` = 8.
  - The capture-state enum `uart_rx_cap_e` {CAP_IDLE, CAP_WAIT_CLR}.
- The storage lives in one sub-module, `uart_sync_fifo`. It has parameters DEPTH and DATA_W; ports clk50, rst_n, push, din, pop, dout, count, full, empty. It is reusable later for the transmit path.
- The top level contains only the capture FSM and the overrun logic.

## Test plan
- Reset mid-stream with 5 bytes buffered → `count` = 0, `m_valid` = 0, `rx_rdy_clr` = 0, with no spurious push after release.
- Receiver presents 0xA5 with `m_ready` = 0 → exactly one `rx_rdy_clr` pulse at N+1; `m_data` = 0xA5, `count` = 1; holding `rx_rdy` high for 2 extra cycles causes no second push.
- Push 16 bytes 0x00..0x0F, then pop all → order is preserved, `full` is high at count 16, and the pointers wrap correctly on a following 3-byte push/pop.
- Full FIFO plus a new byte 0x5A, macro undefined → no `rx_rdy_clr` while full; one pop → 0x5A is captured within 2 cycles and the last entry read is 0x5A.
- Same as above with the macro defined → immediate `rx_rdy_clr`, `overrun` = 1, `count` stays 16, 0x5A is never output; `overrun_clr` → `overrun` = 0.
- Simultaneous push and pop at `count` = 3 → `count` stays 3 and the data order is intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the receive-capture state encoding.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic {
    CAP_IDLE,
    CAP_WAIT_CLR
  } uart_rx_cap_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous circular FIFO with first-word-fall-through read; pushes when full
// and pops when empty are ignored. DEPTH must be a power of two, at least 2.
module uart_sync_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk50,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (ADDR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage is deliberately not reset; only the pointers and occupancy are.
  always_ff @(posedge clk50) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: drains the receiver's dout/rdy handshake into a FIFO.
// Define UART_RX_FIFO_OVERRUN_EN to drop bytes when full and flag a sticky overrun.
//
// Handshakes: the receiver side is level/ack -- rx_rdy stays high until a
// one-cycle rx_rdy_clr pulse; the consumer side is valid/ready -- a pop
// happens on any cycle with m_valid && m_ready, m_data is stable while
// m_valid is high and m_ready is ignored while m_valid is low.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk50,
  input  logic                   rst_n,
  input  logic [UART_DATA_W-1:0] rx_dout,
  input  logic                   rx_rdy,
  output logic                   rx_rdy_clr,
  output logic [UART_DATA_W-1:0] m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [ADDR_W:0]        count,
  output logic                   full
`ifdef UART_RX_FIFO_OVERRUN_EN
  ,
  output logic                   overrun,
  input  logic                   overrun_clr
`endif
);

  uart_rx_cap_e cap_state;
  uart_rx_cap_e cap_state_nxt;
  logic         push;
  logic         clr_nxt;
  logic         empty;
`ifdef UART_RX_FIFO_OVERRUN_EN
  logic         ovr_set;
`endif

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (UART_DATA_W)
  ) u_fifo (
    .clk50 (clk50),
    .rst_n (rst_n),
    .push  (push),
    .din   (rx_dout),
    .pop   (m_ready),
    .dout  (m_data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign m_valid = !empty;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      cap_state  <= CAP_IDLE;
      rx_rdy_clr <= 1'b0;
    end else begin
      cap_state  <= cap_state_nxt;
      rx_rdy_clr <= clr_nxt;
    end
  end

  // Full is the registered flag, so a same-cycle pop never frees room for a push.
  always_comb begin
    cap_state_nxt = cap_state;
    push          = 1'b0;
    clr_nxt       = 1'b0;
`ifdef UART_RX_FIFO_OVERRUN_EN
    ovr_set       = 1'b0;
`endif
    case (cap_state)
      CAP_IDLE: begin
        if (rx_rdy) begin
          if (!full) begin
            push          = 1'b1;
            clr_nxt       = 1'b1;
            cap_state_nxt = CAP_WAIT_CLR;
          end
`ifdef UART_RX_FIFO_OVERRUN_EN
          else begin
            clr_nxt       = 1'b1;
            ovr_set       = 1'b1;
            cap_state_nxt = CAP_WAIT_CLR;
          end
`endif
        end
      end
      // Wait for the receiver to drop rdy so a stale level is not captured twice.
      CAP_WAIT_CLR: begin
        if (!rx_rdy) begin
          cap_state_nxt = CAP_IDLE;
        end
      end
      default: cap_state_nxt = CAP_IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_OVERRUN_EN
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (ovr_set) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table plus hand-written corner sequences.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic                   clk50 = 1'b0;
  logic                   rst_n;
  logic [UART_DATA_W-1:0] rx_dout;
  logic                   rx_rdy;
  logic                   rx_rdy_clr;
  logic [UART_DATA_W-1:0] m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic [ADDR_W:0]        count;
  logic                   full;
`ifdef UART_RX_FIFO_OVERRUN_EN
  logic                   overrun;
  logic                   overrun_clr;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [UART_DATA_W-1:0] exp_q[$];
  logic [UART_DATA_W-1:0] last_popped;

  typedef struct {
    logic [UART_DATA_W-1:0] din;
    logic [ADDR_W:0]        exp_count;
    logic                   exp_full;
  } vec_t;
  vec_t vecs[DEPTH];

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk50       (clk50),
    .rst_n       (rst_n),
    .rx_dout     (rx_dout),
    .rx_rdy      (rx_rdy),
    .rx_rdy_clr  (rx_rdy_clr),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .count       (count),
    .full        (full)
`ifdef UART_RX_FIFO_OVERRUN_EN
    ,
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
`endif
  );

  always #10 clk50 = ~clk50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  // Receiver model: present a byte, wait (bounded) for the clear pulse, then drop rdy.
  task automatic send_byte(input logic [7:0] b, input bit expect_capture, output int waited);
    rx_dout = b;
    rx_rdy  = 1'b1;
    if (expect_capture) exp_q.push_back(b);
    waited = 0;
    do begin
      step();
      waited++;
    end while (!rx_rdy_clr && waited < 20);
    check("rdy_clr_seen", 32'(rx_rdy_clr), 1);
    rx_rdy = 1'b0;
    step();
  endtask

  task automatic pop_one();
    check("pop_has_expected", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      check("m_valid_at_pop", 32'(m_valid), 1);
      last_popped = exp_q.pop_front();
      check("m_data", 32'(m_data), 32'(last_popped));
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 64) begin
      pop_one();
      guard++;
    end
    check("drain_count", 32'(count), 0);
    check("drain_m_valid", 32'(m_valid), 0);
  endtask

  initial begin
    int w;

    rst_n   = 1'b0;
    rx_dout = '0;
    rx_rdy  = 1'b0;
    m_ready = 1'b0;
`ifdef UART_RX_FIFO_OVERRUN_EN
    overrun_clr = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      vecs[i].din       = 8'(i);
      vecs[i].exp_count = (ADDR_W + 1)'(i + 1);
      vecs[i].exp_full  = (i == DEPTH - 1);
    end

    // Reset state
    repeat (3) step();
    check("reset_count", 32'(count), 0);
    check("reset_m_valid", 32'(m_valid), 0);
    check("reset_full", 32'(full), 0);
    check("reset_rdy_clr", 32'(rx_rdy_clr), 0);
`ifdef UART_RX_FIFO_OVERRUN_EN
    check("reset_overrun", 32'(overrun), 0);
`endif
    rst_n = 1'b1;
    step();

    // Single byte 0xA5, consumer stalled, rdy held high for 2 extra cycles
    rx_dout = 8'hA5;
    rx_rdy  = 1'b1;
    exp_q.push_back(8'hA5);
    step();
    check("a5_rdy_clr_n1", 32'(rx_rdy_clr), 1);
    check("a5_count", 32'(count), 1);
    check("a5_m_valid", 32'(m_valid), 1);
    check("a5_m_data", 32'(m_data), 32'hA5);
    for (int i = 0; i < 2; i++) begin
      step();
      check("a5_no_second_clr", 32'(rx_rdy_clr), 0);
      check("a5_no_second_push", 32'(count), 1);
    end
    rx_rdy = 1'b0;
    repeat (2) step();
    check("a5_count_stable", 32'(count), 1);
    drain();

    // Table-driven fill 0x00..0x0F
    for (int i = 0; i < DEPTH; i++) begin
      send_byte(vecs[i].din, 1'b1, w);
      if (i == 0) check("fill_latency", 32'(w), 1);
      check("fill_count", 32'(count), 32'(vecs[i].exp_count));
      check("fill_full", 32'(full), 32'(vecs[i].exp_full));
    end
    drain();
    // Wrap-around after a full lap of both pointers
    for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i), 1'b1, w);
    check("wrap_count", 32'(count), 3);
    drain();

    // Full FIFO plus a new byte 0x5A
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, w);
    check("full_before_5a", 32'(full), 1);
    rx_dout = 8'h5A;
    rx_rdy  = 1'b1;
`ifdef UART_RX_FIFO_OVERRUN_EN
    step();
    check("ovr_rdy_clr", 32'(rx_rdy_clr), 1);
    check("ovr_flag", 32'(overrun), 1);
    check("ovr_count", 32'(count), 16);
    rx_rdy = 1'b0;
    step();
    check("ovr_sticky", 32'(overrun), 1);
    drain();
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("ovr_cleared", 32'(overrun), 0);
`else
    for (int i = 0; i < 4; i++) begin
      step();
      check("full_no_clr", 32'(rx_rdy_clr), 0);
      check("full_count", 32'(count), 16);
    end
    exp_q.push_back(8'h5A);
    pop_one();
    w = 0;
    while (!rx_rdy_clr && w < 2) begin
      step();
      w++;
    end
    check("full_5a_captured", 32'(rx_rdy_clr), 1);
    check("full_5a_count", 32'(count), 16);
    rx_rdy = 1'b0;
    step();
    drain();
    check("full_last_is_5a", 32'(last_popped), 32'h5A);
`endif

    // Simultaneous push and pop at count 3
    send_byte(8'h11, 1'b1, w);
    send_byte(8'h22, 1'b1, w);
    send_byte(8'h33, 1'b1, w);
    check("sim_count_before", 32'(count), 3);
    rx_dout = 8'h77;
    rx_rdy  = 1'b1;
    exp_q.push_back(8'h77);
    last_popped = exp_q.pop_front();
    check("sim_head", 32'(m_data), 32'(last_popped));
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("sim_count_after", 32'(count), 3);
    check("sim_rdy_clr", 32'(rx_rdy_clr), 1);
    rx_rdy = 1'b0;
    step();
    drain();

    // Reset mid-stream with 5 bytes buffered
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, w);
    check("mid_count_before", 32'(count), 5);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_m_valid", 32'(m_valid), 0);
    check("mid_rst_rdy_clr", 32'(rx_rdy_clr), 0);
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_count", 32'(count), 0);
      check("post_rst_rdy_clr", 32'(rx_rdy_clr), 0);
    end
    send_byte(8'hC3, 1'b1, w);
    check("post_rst_latency", 32'(w), 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
